// File: rtl/barcode_reader.sv
// barcode_reader: decodes start-bit-timed 8-bit serial station IDs from an IR barcode line.
// Optional WAIT_FALL timeout enabled by defining BC_TIMEOUT_EN.
module barcode_reader (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld,
    output logic       frm_err
);
    typedef enum logic [1:0] {IDLE, START, WAIT_FALL, SAMPLE} state_t;
    state_t      state_q;
    logic        bc_s1_q, bc_s2_q, bc_s3_q;
    logic [21:0] cnt_q, t_q;
    logic [3:0]  bit_cnt_q;
    logic [7:0]  shift_q, id_q;
    logic        id_vld_q, frm_err_q;
    logic        fall;
    logic [7:0]  shift_nxt;
    assign fall      = bc_s3_q & ~bc_s2_q;
    assign shift_nxt = {shift_q[6:0], bc_s2_q};
    assign ID        = id_q;
    assign ID_vld    = id_vld_q;
    assign frm_err   = frm_err_q;
`ifdef BC_TIMEOUT_EN
    // Counts cycles since the last bit edge; a frame stalled for 4*T is dropped.
    logic [23:0] to_cnt_q;
    logic        timeout;
    assign timeout = to_cnt_q >= {t_q, 2'b00};
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            bc_s1_q   <= 1'b1;
            bc_s2_q   <= 1'b1;
            bc_s3_q   <= 1'b1;
            cnt_q     <= '0;
            t_q       <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            id_q      <= '0;
            id_vld_q  <= 1'b0;
            frm_err_q <= 1'b0;
`ifdef BC_TIMEOUT_EN
            to_cnt_q  <= '0;
`endif
        end else begin
            bc_s1_q   <= BC;
            bc_s2_q   <= bc_s1_q;
            bc_s3_q   <= bc_s2_q;
            frm_err_q <= 1'b0;
            if (clr_ID_vld) id_vld_q <= 1'b0;
            case (state_q)
                IDLE: if (fall) begin
                    state_q   <= START;
                    cnt_q     <= 22'd1;
                    bit_cnt_q <= '0;
                end
                START: if (bc_s2_q) begin
                    t_q     <= cnt_q;
                    state_q <= WAIT_FALL;
`ifdef BC_TIMEOUT_EN
                    to_cnt_q <= 24'd1;
`endif
                end else if (cnt_q == 22'h3FFFFF) begin
                    state_q   <= IDLE;
                    frm_err_q <= 1'b1;
                end else cnt_q <= cnt_q + 22'd1;
                WAIT_FALL: if (fall) begin
                    state_q <= SAMPLE;
                    cnt_q   <= 22'd1;
`ifdef BC_TIMEOUT_EN
                    to_cnt_q <= 24'd1;
                end else if (timeout) begin
                    state_q   <= IDLE;
                    frm_err_q <= 1'b1;
                end else begin
                    to_cnt_q <= to_cnt_q + 24'd1;
`endif
                end
                SAMPLE: begin
`ifdef BC_TIMEOUT_EN
                    to_cnt_q <= to_cnt_q + 24'd1;
`endif
                    if (cnt_q == t_q) begin
                        shift_q   <= shift_nxt;
                        bit_cnt_q <= bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_q <= IDLE;
                            if (shift_nxt[7:6] == 2'b00) begin
                                id_q     <= shift_nxt;
                                id_vld_q <= 1'b1;
                            end else frm_err_q <= 1'b1;
                        end else state_q <= WAIT_FALL;
                    end else cnt_q <= cnt_q + 22'd1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_barcode_reader.sv
// tb_barcode_reader: directed frames with a scoreboard queue checked by an output monitor.
module tb_barcode_reader;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       BC = 1'b1;
    logic       clr_ID_vld = 1'b0;
    logic [7:0] ID;
    logic       ID_vld;
    logic       frm_err;

    typedef struct {
        bit         is_err;
        logic [7:0] id;
        int         cyc;
    } exp_t;

    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         cyc = 0;
    int         err_seen = 0;
    bit         must_hold = 1'b0;
    logic       pv = 1'b0;
    logic [7:0] pid = 8'h00;

    barcode_reader dut (
        .clk(clk), .rst_n(rst_n), .BC(BC), .clr_ID_vld(clr_ID_vld),
        .ID(ID), .ID_vld(ID_vld), .frm_err(frm_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor: an output event is a frm_err pulse or a newly set/changed valid ID
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (must_hold) check("id_vld_hold", {31'd0, ID_vld}, 32'd1);
            if (frm_err || (ID_vld && (!pv || ID != pid))) begin
                if (frm_err) err_seen++;
                if (sb.size() == 0) begin
                    check("unexpected_event", {23'd0, frm_err, ID}, 32'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", {31'd0, frm_err}, {31'd0, e.is_err});
                    if (!e.is_err) check("event_id", {24'd0, ID}, {24'd0, e.id});
                    if (e.cyc >= 0) check("event_cycle", cyc, e.cyc);
                end
            end
        end
        pv  = ID_vld;
        pid = ID;
    end

    task automatic drive_bit(input bit b, input int t);
        BC = 1'b0;
        repeat (b ? t / 2 : 3 * t / 2) @(posedge clk);
        #1 BC = 1'b1;
        repeat (b ? 3 * t / 2 : t / 2) @(posedge clk);
        #1;
    endtask

    // ID_vld/frm_err update lands t+3 edges after the last bit's falling edge is driven
    task automatic send(input logic [7:0] v, input int t, input int nbits, input bit clr_end);
        BC = 1'b0;
        repeat (t) @(posedge clk);
        #1 BC = 1'b1;
        repeat (t) @(posedge clk);
        #1;
        for (int i = 0; i < nbits; i++) begin
            if (i == 7) begin
                sb.push_back('{v[7:6] != 2'b00, v, cyc + t + 3});
                if (clr_end) begin
                    fork
                        drive_bit(v[7 - i], t);
                        begin
                            repeat (t + 2) @(posedge clk);
                            #1 clr_ID_vld = 1'b1;
                            @(posedge clk);
                            #1 clr_ID_vld = 1'b0;
                        end
                    join
                end else drive_bit(v[7 - i], t);
            end else drive_bit(v[7 - i], t);
        end
    endtask

    task automatic pulse_reset();
        BC = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ID", {24'd0, ID}, 32'h00);
        check("rst_ID_vld", {31'd0, ID_vld}, 32'd0);
        check("rst_frm_err", {31'd0, frm_err}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        int e0;
        repeat (2) @(posedge clk);
        #1;
        pulse_reset();
        send(8'h3B, 2048, 8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("3B_ID", {24'd0, ID}, 32'h3B);
        check("3B_vld", {31'd0, ID_vld}, 32'd1);
        check("3B_no_err", err_seen, 0);
        send(8'hC5, 64, 8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("C5_ID_kept", {24'd0, ID}, 32'h3B);
        check("C5_vld_kept", {31'd0, ID_vld}, 32'd1);
        check("C5_one_err", err_seen, 1);
        clr_ID_vld = 1'b1;
        @(posedge clk);
        #1 clr_ID_vld = 1'b0;
        check("clr_vld", {31'd0, ID_vld}, 32'd0);
        send(8'h0D, 64, 8, 1'b0);
        must_hold = 1'b1;
        send(8'h2A, 64, 8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        must_hold = 1'b0;
        check("b2b_ID", {24'd0, ID}, 32'h2A);
        send(8'h33, 64, 8, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        check("clr_coincident_vld", {31'd0, ID_vld}, 32'd1);
        check("clr_coincident_ID", {24'd0, ID}, 32'h33);
        send(8'h2C, 2, 8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("t2_ID", {24'd0, ID}, 32'h2C);
        e0 = err_seen;
`ifdef BC_TIMEOUT_EN
        sb.push_back('{1'b1, 8'h00, -1});
`endif
        send(8'h12, 512, 3, 1'b0);
        repeat (3000) @(posedge clk);
        #1;
`ifdef BC_TIMEOUT_EN
        check("timeout_err", err_seen - e0, 1);
`else
        check("no_timeout_err", err_seen - e0, 0);
`endif
        check("stall_ID_kept", {24'd0, ID}, 32'h2C);
        pulse_reset();
        send(8'h15, 64, 4, 1'b0);
        pulse_reset();
        check("rst_mid_no_err", err_seen - e0, 32'(0
`ifdef BC_TIMEOUT_EN
            + 1
`endif
        ));
        send(8'h15, 64, 8, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        check("15_ID", {24'd0, ID}, 32'h15);
        check("15_vld", {31'd0, ID_vld}, 32'd1);
        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/barcode_reader.md
BARCODE_READER -- requirements
Module: barcode_reader

Interface
REQ-001 The block SHALL have one clock, clk, and an asynchronous active-low reset, rst_n.
REQ-002 Port clk, input, 1 bit: system clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port BC, input, 1 bit: raw serial barcode line from the IR barcode sensor; asynchronous to clk; idles high.
REQ-005 Port clr_ID_vld, input, 1 bit: single-cycle acknowledge from command control; clears ID_vld.
REQ-006 Port ID, output, 8 bits: last valid station ID, MSB first as received.
REQ-007 Port ID_vld, output, 1 bit: a new valid ID is held in ID.
REQ-008 Port frm_err, output, 1 bit: one-cycle pulse on a rejected or aborted frame.

Function
REQ-009 BC SHALL pass through a two-flop synchronizer; every later reference to BC means the synchronized value.
REQ-010 A falling edge SHALL be detected as synchronized BC high in the previous cycle and low in the current cycle.
REQ-011 The frame format SHALL be one start bit followed by 8 data bits, MSB first, and each bit slot SHALL begin with a falling edge of BC.
REQ-012 The start bit is low for T cycles; T SHALL be measured with a 22-bit counter running from the start falling edge until the first cycle BC reads high.
REQ-013 For each data bit, the block SHALL wait for the falling edge, count T cycles, and then sample BC: low means 0, high means 1.
REQ-014 State machine: IDLE -> START on a falling edge.
REQ-015 State machine: START -> WAIT_FALL when BC rises, with T latched.
REQ-016 State machine: WAIT_FALL -> SAMPLE on a falling edge.
REQ-017 State machine: SAMPLE -> WAIT_FALL after a sample while bits remain.
REQ-018 State machine: after the 8th sample -> IDLE, with the result evaluated in the same cycle.
REQ-019 A 4-bit bit counter SHALL count samples 0..8 and clear on entry to START.
REQ-020 Data bits SHALL shift into an 8-bit shift register separate from ID.
REQ-021 Accept rule: if shift[7:6]==2'b00, then ID <= shift and ID_vld <= 1 on the clock after the 8th sample (latency 1).
REQ-022 Reject rule: if shift[7:6]!=2'b00, then ID and ID_vld are unchanged and frm_err pulses for one cycle.
REQ-023 ID_vld SHALL clear on clr_ID_vld; if clr_ID_vld and a set occur in the same cycle, the set SHALL win.
REQ-024 A new valid frame while ID_vld=1 SHALL overwrite ID and keep ID_vld=1.
REQ-025 If the START counter saturates at 22'h3FFFFF, the block SHALL abort to IDLE with a frm_err pulse.
REQ-026 A measured T of 0 is impossible (minimum 1); T=1 SHALL sample on the cycle after the falling edge.
REQ-027 Falling edges seen in SAMPLE before the count reaches T SHALL be ignored.

Reset
REQ-028 On rst_n=0: state=IDLE, ID=8'h00, ID_vld=0, frm_err=0, counters=0, shift register=0, synchronizer flops=1 (idle high).
REQ-029 Reset asserted mid-frame SHALL abandon the frame with no ID_vld and no frm_err.
REQ-030 After release, the first falling edge SHALL start a fresh frame.

Configuration
REQ-031 With macro BC_TIMEOUT_EN defined, the WAIT_FALL state SHALL count idle cycles.
REQ-032 With BC_TIMEOUT_EN defined, if 4*T cycles (saturating at 24 bits) elapse with no falling edge, the block SHALL go to IDLE and pulse frm_err.
REQ-033 With BC_TIMEOUT_EN undefined, WAIT_FALL SHALL wait indefinitely, and the timeout counter and its logic SHALL be absent.

Verification
REQ-034 Frame 8'h3B with T=2048 (start low 2048 cycles, period 4096) -> ID=8'h3B, ID_vld=1 one cycle after the 8th sample, frm_err never asserted.
REQ-035 Frame 8'hC5 -> ID keeps its previous value 8'h3B, ID_vld unchanged, exactly one frm_err pulse.
REQ-036 ID_vld=1, then pulse clr_ID_vld -> ID_vld=0 next cycle; clr_ID_vld coincident with a valid frame end -> ID_vld stays 1.
REQ-037 Frames 8'h0D then 8'h2A back-to-back without clearing -> ID=8'h2A, ID_vld=1 throughout after the first frame.
REQ-038 rst_n pulsed low after bit 4 of frame 8'h15 -> outputs return to reset values; the following clean frame 8'h15 decodes correctly.
REQ-039 With BC_TIMEOUT_EN defined, stop BC after 3 data bits (T=512) -> frm_err pulse 2048 cycles after the last falling edge and return to IDLE; with the macro undefined -> no pulse, and the block stays in WAIT_FALL.
